// File: rtl/rgb_pattern_gen_if.sv
// rtl/rgb_pattern_gen_if.sv - raster input and RGB565 output bundle for rgb_pattern_gen
interface rgb_pattern_gen_if;
    logic       in_hs;
    logic       in_vs;
    logic       in_de;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic       out_hs;
    logic       out_vs;
    logic       out_de;
    logic [4:0] out_r;
    logic [5:0] out_g;
    logic [4:0] out_b;

    modport master (
        output in_hs, in_vs, in_de, in_x, in_y,
        input  out_hs, out_vs, out_de, out_r, out_g, out_b
    );

    modport slave (
        input  in_hs, in_vs, in_de, in_x, in_y,
        output out_hs, out_vs, out_de, out_r, out_g, out_b
    );
endinterface

// File: rtl/rgb_pattern_gen.sv
// rtl/rgb_pattern_gen.sv - multi-pattern RGB565 test source with frame-aligned pattern switching
module rgb_pattern_gen #(
    parameter int H_ACTIVE           = 800,
    parameter int V_ACTIVE           = 480,
    parameter bit SYNC_POL           = 1'b0,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int BOX_SIZE           = 64,
    parameter int BOX_STEP           = 2
) (
    input  logic               rgb_clk,
    input  logic               rgb_rst_n,
    rgb_pattern_gen_if.slave   vid,
    input  logic               auto_mode,
    input  logic [2:0]         pattern_sel,
    output logic [2:0]         cur_pattern
);
    localparam logic        SYNC_IDLE  = ~SYNC_POL;
    localparam logic [9:0]  BAR16_W    = 10'(H_ACTIVE / 16);
    localparam logic [9:0]  BAR8_W     = 10'(H_ACTIVE / 8);
    localparam logic [9:0]  X_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST     = 10'(V_ACTIVE - 1);
    localparam logic [7:0]  FRAME_LAST = 8'(FRAMES_PER_PATTERN - 1);
    localparam logic [15:0] WHITE      = 16'hFFFF;
    localparam logic [15:0] DARK_BLUE  = 16'h0008;

    localparam logic [2:0] PAT_BARS16  = 3'd0;
    localparam logic [2:0] PAT_SMPTE   = 3'd1;
    localparam logic [2:0] PAT_CHECKER = 3'd2;
    localparam logic [2:0] PAT_RAMP    = 3'd3;
    localparam logic [2:0] PAT_BORDER  = 3'd4;
    localparam logic [2:0] PAT_BOX     = 3'd5;

    // Returns {new_dir, new_pos}; sums are 11 bits wide so the edge test never wraps.
    function automatic logic [10:0] box_next(input logic [9:0] pos, input logic dir,
                                             input logic [10:0] lim);
        logic [10:0] p;
        p = {1'b0, pos};
        if (dir) begin
            if (p + 11'(BOX_SIZE) + 11'(BOX_STEP) > lim)
                return {1'b0, 10'(p - 11'(BOX_STEP))};
            return {1'b1, 10'(p + 11'(BOX_STEP))};
        end
        if (p < 11'(BOX_STEP))
            return {1'b1, 10'(p + 11'(BOX_STEP))};
        return {1'b0, 10'(p - 11'(BOX_STEP))};
    endfunction

    logic        s1_hs, s1_vs, s1_de;
    logic [15:0] s1_bar_word;
    logic [15:0] s1_smpte;
    logic        s1_check;
    logic [5:0]  s1_ramp;
    logic        s1_border;
    logic        s1_in_box;
    logic        fs_armed;

    logic [7:0]  frame_cnt;
    logic [9:0]  box_x, box_y;
    logic        dir_x, dir_y;

    logic        fs;
    logic [9:0]  bar16_idx, bar8_idx;
    logic [15:0] bar_word, smpte_rgb, pix_rgb;
    logic        box_hit;

    // s1_vs doubles as the previous in_vs; fs_armed blocks a spurious edge right after reset.
    assign fs = (vid.in_vs == SYNC_POL) && (s1_vs != SYNC_POL) && fs_armed;

    assign bar16_idx = vid.in_x / BAR16_W;
    assign bar8_idx  = vid.in_x / BAR8_W;
    assign bar_word  = 16'h8000 >> bar16_idx;
    assign box_hit   = (vid.in_x >= box_x) && ({1'b0, vid.in_x} < {1'b0, box_x} + 11'(BOX_SIZE)) &&
                       (vid.in_y >= box_y) && ({1'b0, vid.in_y} < {1'b0, box_y} + 11'(BOX_SIZE));

    always_comb begin
        smpte_rgb = 16'h0000;
        case (bar8_idx)
            10'd0:   smpte_rgb = 16'hFFFF;
            10'd1:   smpte_rgb = 16'hFFE0;
            10'd2:   smpte_rgb = 16'h07FF;
            10'd3:   smpte_rgb = 16'h07E0;
            10'd4:   smpte_rgb = 16'hF81F;
            10'd5:   smpte_rgb = 16'hF800;
            10'd6:   smpte_rgb = 16'h001F;
            default: smpte_rgb = 16'h0000;
        endcase
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            s1_hs       <= SYNC_IDLE;
            s1_vs       <= SYNC_IDLE;
            s1_de       <= 1'b0;
            s1_bar_word <= '0;
            s1_smpte    <= '0;
            s1_check    <= 1'b0;
            s1_ramp     <= '0;
            s1_border   <= 1'b0;
            s1_in_box   <= 1'b0;
            fs_armed    <= 1'b0;
        end else begin
            s1_hs       <= vid.in_hs;
            s1_vs       <= vid.in_vs;
            s1_de       <= vid.in_de;
            s1_bar_word <= bar_word;
            s1_smpte    <= smpte_rgb;
            s1_check    <= vid.in_x[5] ^ vid.in_y[5];
            s1_ramp     <= vid.in_x[9:4];
            s1_border   <= (vid.in_x == 10'd0) || (vid.in_x == X_LAST) ||
                           (vid.in_y == 10'd0) || (vid.in_y == Y_LAST);
            s1_in_box   <= box_hit;
            fs_armed    <= 1'b1;
        end
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            cur_pattern <= 3'd0;
            frame_cnt   <= 8'd0;
            box_x       <= 10'd0;
            box_y       <= 10'd0;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
        end else if (fs) begin
            if (!auto_mode) begin
                cur_pattern <= pattern_sel;
                frame_cnt   <= 8'd0;
            end else if (frame_cnt >= FRAME_LAST) begin
                frame_cnt   <= 8'd0;
                cur_pattern <= (cur_pattern >= PAT_BOX) ? PAT_BARS16 : cur_pattern + 3'd1;
            end else begin
                frame_cnt   <= frame_cnt + 8'd1;
            end
            {dir_x, box_x} <= box_next(box_x, dir_x, 11'(H_ACTIVE));
            {dir_y, box_y} <= box_next(box_y, dir_y, 11'(V_ACTIVE));
        end
    end

    always_comb begin
        pix_rgb = 16'h0000;
        if (s1_de) begin
            case (cur_pattern)
                PAT_BARS16:  pix_rgb = s1_bar_word;
                PAT_SMPTE:   pix_rgb = s1_smpte;
                PAT_CHECKER: pix_rgb = s1_check ? 16'h0000 : WHITE;
                PAT_RAMP:    pix_rgb = {s1_ramp[5:1], s1_ramp, s1_ramp[5:1]};
                PAT_BORDER:  pix_rgb = s1_border ? WHITE : 16'h0000;
                PAT_BOX:     pix_rgb = s1_in_box ? WHITE : DARK_BLUE;
                default:     pix_rgb = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            vid.out_hs <= SYNC_IDLE;
            vid.out_vs <= SYNC_IDLE;
            vid.out_de <= 1'b0;
            vid.out_r  <= '0;
            vid.out_g  <= '0;
            vid.out_b  <= '0;
        end else begin
            vid.out_hs <= s1_hs;
            vid.out_vs <= s1_vs;
            vid.out_de <= s1_de;
            {vid.out_r, vid.out_g, vid.out_b} <= pix_rgb;
        end
    end
endmodule

// File: tb/tb_rgb_pattern_gen.sv
// tb/tb_rgb_pattern_gen.sv - self-checking bench for rgb_pattern_gen against a frame-level model
module tb_rgb_pattern_gen;
    localparam int H   = 800;
    localparam int V   = 480;
    localparam int FPP = 3;
    localparam int BS  = 64;
    localparam int ST  = 2;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] rgb;
    } exp_t;

    localparam exp_t RST_E = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 16'h0000};

    logic       rgb_clk;
    logic       rgb_rst_n;
    logic       auto_mode;
    logic [2:0] pattern_sel;
    logic [2:0] cur_pattern;

    rgb_pattern_gen_if vid();

    rgb_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(1'b0),
        .FRAMES_PER_PATTERN(FPP), .BOX_SIZE(BS), .BOX_STEP(ST)
    ) dut (
        .rgb_clk(rgb_clk),
        .rgb_rst_n(rgb_rst_n),
        .vid(vid),
        .auto_mode(auto_mode),
        .pattern_sel(pattern_sel),
        .cur_pattern(cur_pattern)
    );

    initial rgb_clk = 1'b0;
    always #5 rgb_clk = ~rgb_clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_pat, m_cnt, m_nfs;
    bit   m_prev_act, m_first;
    exp_t e0, e1;

    // Box position as a triangle wave in the number of frame starts since reset.
    function automatic int tri_pos(int n, int lim);
        int k, m;
        k = (lim - BS) / ST;
        m = n % (2 * k);
        return (m <= k) ? m * ST : (2 * k - m) * ST;
    endfunction

    function automatic logic [15:0] exp_pix(int pat, int x, int y, int nfs);
        int bx, by;
        case (pat)
            0: return 16'h8000 >> (x / (H / 16));
            1: case (x / (H / 8))
                   0: return 16'hFFFF;
                   1: return 16'hFFE0;
                   2: return 16'h07FF;
                   3: return 16'h07E0;
                   4: return 16'hF81F;
                   5: return 16'hF800;
                   6: return 16'h001F;
                   default: return 16'h0000;
               endcase
            2: return (((x / 32) + (y / 32)) % 2 == 1) ? 16'h0000 : 16'hFFFF;
            3: return 16'(((x / 32) << 11) | ((x / 16) << 5) | (x / 32));
            4: return (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? 16'hFFFF : 16'h0000;
            5: begin
                bx = tri_pos(nfs, H);
                by = tri_pos(nfs, V);
                return (x >= bx && x < bx + BS && y >= by && y < by + BS) ? 16'hFFFF : 16'h0008;
            end
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 0; m_cnt = 0; m_nfs = 0;
        m_prev_act = 1'b0; m_first = 1'b1;
        e0 = RST_E; e1 = RST_E;
    endtask

    // Called at a falling edge: check outputs for the inputs of two edges ago, then drive new inputs.
    task automatic step(input int hs, input int vs, input int de, input int x, input int y);
        bit act, fs;
        chk("out_hs", 16'(vid.out_hs), 16'(e1.hs));
        chk("out_vs", 16'(vid.out_vs), 16'(e1.vs));
        chk("out_de", 16'(vid.out_de), 16'(e1.de));
        chk("rgb", {vid.out_r, vid.out_g, vid.out_b}, e1.rgb);
        chk("cur_pattern", 16'(cur_pattern), 16'(m_pat));
        e1 = e0;
        vid.in_hs = 1'(hs);
        vid.in_vs = 1'(vs);
        vid.in_de = 1'(de);
        vid.in_x  = 10'(x);
        vid.in_y  = 10'(y);
        act = (vs == 0);
        fs = act && !m_prev_act && !m_first;
        m_first = 1'b0;
        m_prev_act = act;
        if (fs) begin
            if (!auto_mode) begin
                m_pat = int'(pattern_sel);
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == FPP) begin
                    m_cnt = 0;
                    m_pat = (m_pat + 1) % 6;
                end
            end
            m_nfs++;
        end
        e0.hs  = 1'(hs);
        e0.vs  = 1'(vs);
        e0.de  = 1'(de);
        e0.rgb = (de != 0) ? exp_pix(m_pat, x, y, m_nfs) : 16'h0000;
        @(negedge rgb_clk);
    endtask

    task automatic frame_start();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
    endtask

    task automatic pix(input int x, input int y);
        step(1, 1, 1, x, y);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_de"}, 16'(vid.out_de), 16'd0);
        chk({tag, "_hs"}, 16'(vid.out_hs), 16'd1);
        chk({tag, "_vs"}, 16'(vid.out_vs), 16'd1);
        chk({tag, "_rgb"}, {vid.out_r, vid.out_g, vid.out_b}, 16'h0000);
        chk({tag, "_pat"}, 16'(cur_pattern), 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bx, by;
        rgb_rst_n = 1'b0;
        auto_mode = 1'b0;
        pattern_sel = 3'd3;
        vid.in_hs = 1'b1; vid.in_vs = 1'b1; vid.in_de = 1'b0;
        vid.in_x = '0; vid.in_y = '0;
        model_reset();
        repeat (3) @(negedge rgb_clk);
        check_reset_outputs("por");
        rgb_rst_n = 1'b1;

        // vs already active on the first cycle out of reset must not count as a frame start
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);

        pattern_sel = 3'd1;
        frame_start();
        pix(0, 10); pix(100, 10); pix(700, 10);
        pattern_sel = 3'd0;
        pix(0, 11); pix(100, 11); pix(700, 11);
        frame_start();
        pix(0, 20); pix(50, 20); pix(799, 20);
        pattern_sel = 3'd2;
        frame_start();
        pix(0, 0); pix(32, 0); pix(32, 32);
        pattern_sel = 3'd4;
        frame_start();
        pix(400, 479); pix(400, 240); pix(0, 5); pix(799, 5);

        for (int p = 0; p < 8; p++) begin
            pattern_sel = 3'(p);
            frame_start();
            for (int i = 0; i < 40; i++) begin
                if (i == 20) pattern_sel = 3'($urandom_range(0, 7));
                step($urandom_range(0, 1), 1, $urandom_range(0, 1),
                     $urandom_range(0, H - 1), $urandom_range(0, V - 1));
            end
        end

        // reset asserted mid-line with de held high
        pattern_sel = 3'd1;
        frame_start();
        pix(10, 10); pix(120, 10); pix(230, 10);
        rgb_rst_n = 1'b0;
        vid.in_de = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        for (int i = 0; i < 5; i++) begin
            @(negedge rgb_clk);
            check_reset_outputs("rst_hold");
        end
        rgb_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) pix(i * 130, 100);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);

        auto_mode = 1'b1;
        for (int f = 0; f < 20; f++) begin
            frame_start();
            for (int i = 0; i < 3; i++) pix($urandom_range(0, H - 1), $urandom_range(0, V - 1));
        end
        chk("auto_after_20", 16'(cur_pattern), 16'd0);

        auto_mode = 1'b0;
        pattern_sel = 3'd5;
        for (int f = 0; f < 760; f++) begin
            frame_start();
            bx = tri_pos(m_nfs, H);
            by = tri_pos(m_nfs, V);
            if (bx > 0) pix(bx - 1, by);
            pix(bx, by);
            pix(bx + BS - 1, by + BS - 1);
            if (bx + BS < H) pix(bx + BS, by);
            if (by > 0) pix(bx, by - 1);
            if (by + BS < V) pix(bx, by + BS);
            pix($urandom_range(0, H - 1), $urandom_range(0, V - 1));
        end
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
